// File: rtl/bucket_drain_if.sv
// Storage read port plus the drained bucket stream of bucket_drain.
interface bucket_drain_if #(
  parameter int N   = 3,
  parameter int W   = 32,
  parameter int D_L = 16,
  parameter int M   = 32
);
  logic [D_L-1:0] bs_rd_addr;
  logic [M-1:0]   bs_rd_meta;
  logic [N*W-1:0] bs_rd_data;
  logic [M-1:0]   bs_rd_meta_o;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_data;
  logic [D_L-1:0] out_addr;
  logic           out_last;

  modport master (
    output bs_rd_addr, bs_rd_meta, out_valid, out_data, out_addr, out_last,
    input  bs_rd_data, bs_rd_meta_o, out_ready
  );
  modport slave (
    input  bs_rd_addr, bs_rd_meta, out_valid, out_data, out_addr, out_last,
    output bs_rd_data, bs_rd_meta_o, out_ready
  );
endinterface

// File: rtl/bucket_drain.sv
// Streams a range of buckets out of latency-RD_LAT storage through a credit-
// guarded skid FIFO, then publishes a fresh epoch timestamp.
module bucket_drain #(
  parameter int N      = 3,
  parameter int W      = 32,
  parameter int D      = 65536,
  parameter int D_L    = $clog2(D),
  parameter int M      = 32,
  parameter int RD_LAT = 7,
  parameter int FIFO_D = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [D_L-1:0] first_addr,
  input  logic [D_L-1:0] last_addr,
  input  logic [63:0]    timestamp,
  output logic           busy,
  output logic           done,
  output logic [63:0]    epoch_ts,
  bucket_drain_if.master bus
);
  localparam int FW  = N*W + D_L + 1;
  localparam int FA  = $clog2(FIFO_D);
  localparam int CW  = $clog2(FIFO_D+1);
  localparam int WCW = $clog2(RD_LAT+1);

  generate
    if (M < D_L+2) begin : g_bad_meta
      $error("bucket_drain: M must hold addr, last and valid");
    end
    if (FIFO_D < RD_LAT+2) begin : g_bad_fifo
      $error("bucket_drain: FIFO_D must cover the read pipeline");
    end
  endgenerate

  typedef enum logic [2:0] {WARM, IDLE, ISSUE, FLUSH, FIN} state_t;

  state_t         state;
  logic [WCW-1:0] warm_cnt;
  logic [D_L-1:0] cur, last_q;
  logic           empty_q;
  logic [CW-1:0]  credits;
  logic [FW-1:0]  mem [FIFO_D];
  logic [FA-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           issue, push, pop;
  logic           unused_meta;

  assign issue = (state == ISSUE) && !empty_q && (credits != '0);
  // Returns landing during WARM belong to an aborted drain and are dropped.
  assign push  = (state != WARM) && bus.bs_rd_meta_o[D_L+1];
  assign pop   = bus.out_valid && bus.out_ready;
  assign unused_meta = ^bus.bs_rd_meta_o;

  assign bus.out_valid = (count != '0);
  assign {bus.out_data, bus.out_addr, bus.out_last} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.bs_rd_data, bus.bs_rd_meta_o[D_L-1:0], bus.bs_rd_meta_o[D_L]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      credits <= CW'(FIFO_D);
    end else begin
      if (push) wr_ptr <= (wr_ptr == FA'(FIFO_D-1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == FA'(FIFO_D-1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (issue && !pop)      credits <= credits - 1'b1;
      else if (pop && !issue) credits <= credits + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= WARM;
      warm_cnt       <= '0;
      busy           <= 1'b1;
      done           <= 1'b0;
      epoch_ts       <= '0;
      cur            <= '0;
      last_q         <= '0;
      empty_q        <= 1'b0;
      bus.bs_rd_addr <= '0;
      bus.bs_rd_meta <= '0;
    end else begin
      done           <= 1'b0;
      bus.bs_rd_meta <= '0;
      case (state)
        WARM: begin
          if (warm_cnt == WCW'(RD_LAT)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            warm_cnt <= warm_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (start) begin
            cur     <= first_addr;
            last_q  <= last_addr;
            empty_q <= (first_addr > last_addr);
            state   <= ISSUE;
            busy    <= 1'b1;
          end
        end
        ISSUE: begin
          if (empty_q) begin
            state <= FIN;
            done  <= 1'b1;
          end else if (issue) begin
            bus.bs_rd_addr <= cur;
            bus.bs_rd_meta <= M'({1'b1, cur == last_q, cur});
            // Stop on last_q rather than incrementing, so D-1 never wraps to 0.
            if (cur == last_q) state <= FLUSH;
            else               cur   <= cur + 1'b1;
          end
        end
        FLUSH: begin
          if (pop && bus.out_last) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          epoch_ts <= timestamp;
          state    <= IDLE;
          busy     <= 1'b0;
        end
        default: state <= WARM;
      endcase
    end
  end
endmodule

// File: tb/tb_bucket_drain.sv
// Directed bench for bucket_drain: delay-line storage model, scoreboard of
// expected beats, and timing/reset checks.
module tb_bucket_drain;
  localparam int N = 3, W = 32, D = 65536, D_L = 16, M = 32, RD_LAT = 7, FIFO_D = 16;

  typedef struct { logic [D_L-1:0] addr; logic last; } exp_t;

  logic           clk, rst_n, start, busy, done, out_ready;
  logic [D_L-1:0] first_addr, last_addr;
  logic [63:0]    timestamp, epoch_ts;

  bucket_drain_if #(.N(N), .W(W), .D_L(D_L), .M(M)) bus ();

  bucket_drain #(.N(N), .W(W), .D(D), .D_L(D_L), .M(M), .RD_LAT(RD_LAT), .FIFO_D(FIFO_D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_addr(first_addr), .last_addr(last_addr),
    .timestamp(timestamp), .busy(busy), .done(done), .epoch_ts(epoch_ts), .bus(bus)
  );

  initial begin clk = 0; forever #5 clk = ~clk; end

  function automatic logic [N*W-1:0] bdata(input logic [D_L-1:0] a);
    return {a ^ 16'h5a5a, 16'hc0de, ~a, a * 16'd3, 16'h1234, a};
  endfunction

  // Storage model: fixed RD_LAT delay line, deliberately never reset.
  logic [M-1:0]   mpipe [RD_LAT];
  logic [N*W-1:0] dpipe [RD_LAT];
  initial for (int i = 0; i < RD_LAT; i++) begin mpipe[i] = '0; dpipe[i] = '0; end
  always @(posedge clk) begin
    mpipe[0] <= bus.bs_rd_meta;
    dpipe[0] <= bdata(bus.bs_rd_addr);
    for (int i = 1; i < RD_LAT; i++) begin mpipe[i] <= mpipe[i-1]; dpipe[i] <= dpipe[i-1]; end
  end
  assign bus.bs_rd_meta_o = mpipe[RD_LAT-1];
  assign bus.bs_rd_data   = dpipe[RD_LAT-1];
  assign bus.out_ready    = out_ready;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin timestamp = 64'ha5a5_0000_0000_0000; forever begin @(posedge clk); #1; timestamp = timestamp + 1; end end

  int checks = 0, failures = 0;
  exp_t exp_q[$];
  int reads, beats, zero_reads, first_rd, first_beat, last_beat, done_cnt = 0, done_cyc;
  logic [63:0] done_ts;
  bit hold_v = 0;
  logic [N*W+D_L:0] hold_d;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.bs_rd_meta[D_L+1]) begin
      reads++;
      if (first_rd < 0) first_rd = cyc;
      if (bus.bs_rd_addr == '0) zero_reads++;
    end
    if (hold_v) begin
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_stable", {bus.out_data, bus.out_addr, bus.out_last}, hold_d);
    end
    hold_v = bus.out_valid && !bus.out_ready;
    hold_d = {bus.out_data, bus.out_addr, bus.out_last};
    if (bus.out_valid && bus.out_ready) begin
      beats++;
      if (first_beat < 0) first_beat = cyc;
      if (bus.out_last) last_beat = cyc;
      chk("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat_addr", bus.out_addr, e.addr);
        chk("beat_last", bus.out_last, e.last);
        chk("beat_data", bus.out_data, bdata(e.addr));
      end
    end
    if (done) begin done_cnt++; done_cyc = cyc; done_ts = timestamp; end
  end

  int start_cyc;

  task automatic clear_stats();
    reads = 0; beats = 0; zero_reads = 0; first_rd = -1; first_beat = -1; last_beat = -1;
  endtask

  task automatic drain(input logic [D_L-1:0] f, input logic [D_L-1:0] l, input int stall,
                       input bit poke, input string tag);
    int dc0, guard;
    if (f <= l) for (int a = f; a <= l; a++) exp_q.push_back('{addr: D_L'(a), last: (a == l)});
    clear_stats();
    dc0 = done_cnt;
    if (stall > 0) out_ready = 0;
    first_addr = f; last_addr = l; start = 1; start_cyc = cyc;
    tick(1);
    start = 0;
    guard = 0;
    while (done_cnt == dc0 && guard < 3000) begin
      guard++;
      if (stall > 0 && guard == stall) begin
        chk({tag, "_reads_at_stall"}, reads, FIFO_D);
        out_ready = 1;
      end
      if (poke && guard == 5) begin first_addr = 100; last_addr = 200; start = 1; end
      else start = 0;
      tick(1);
    end
    start = 0;
    chk({tag, "_done_once"}, done_cnt - dc0, 1);
    chk({tag, "_epoch"}, epoch_ts, done_ts);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int n;
    rst_n = 0; start = 0; out_ready = 1; first_addr = '0; last_addr = '0;
    clear_stats();
    tick(2);
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_meta", bus.bs_rd_meta, 0);
    chk("rst_rd_addr", bus.bs_rd_addr, 0);
    chk("rst_epoch", epoch_ts, 0);
    rst_n = 1;
    n = 1;
    for (int g = 0; g < 50; g++) begin tick(1); if (busy) n++; else break; end
    chk("warm_len_init", n, RD_LAT + 1);

    // Basic drain with latency and done timing.
    drain(0, 15, 0, 0, "r0_15");
    chk("r0_15_beats", beats, 16);
    chk("r0_15_latency", first_beat - first_rd, RD_LAT + 1);
    chk("r0_15_done_gap", done_cyc - last_beat, 1);
    tick(3);

    // Backpressure: credits cap outstanding reads at FIFO_D.
    drain(0, 63, 40, 0, "r0_63");
    chk("r0_63_beats", beats, 64);
    chk("r0_63_reads", reads, 64);
    tick(3);

    drain(5, 4, 0, 0, "empty");
    chk("empty_reads", reads, 0);
    chk("empty_beats", beats, 0);
    chk("empty_done_gap", done_cyc - start_cyc, 2);
    tick(3);

    drain(16'(D-2), 16'(D-1), 0, 0, "top");
    chk("top_beats", beats, 2);
    chk("top_no_wrap", zero_reads, 0);
    tick(3);

    drain(20, 35, 0, 1, "poke");
    chk("poke_beats", beats, 16);
    tick(3);

    // Reset in the middle of a drain.
    for (int a = 0; a < 32; a++) exp_q.push_back('{addr: D_L'(a), last: (a == 31)});
    clear_stats();
    first_addr = 0; last_addr = 31; start = 1;
    tick(1);
    start = 0;
    tick(13);
    rst_n = 0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_meta", bus.bs_rd_meta, 0);
    chk("mid_rst_rd_addr", bus.bs_rd_addr, 0);
    exp_q.delete();
    tick(1);
    rst_n = 1;
    n = 1;
    clear_stats();
    for (int g = 0; g < 50; g++) begin
      start = (n == 2);
      first_addr = 0; last_addr = 3;
      tick(1);
      if (busy) n++; else break;
    end
    start = 0;
    chk("warm_len_mid", n, RD_LAT + 1);
    tick(10);
    chk("warm_start_ignored_reads", reads, 0);
    chk("warm_absorbed_beats", beats, 0);
    chk("no_done_after_abort", done, 0);
    drain(0, 3, 0, 0, "post_rst");
    chk("post_rst_beats", beats, 4);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bucket_drain.md
BUCKET_DRAIN -- requirements
Module: bucket_drain

Interface
REQ-001 Parameters SHALL be (name, default, meaning): N, 3, words per bucket; W, 32, word width; D, 65536, bucket count; D_L, $clog2(D), address width; M, 32, storage meta width; RD_LAT, 7, storage read latency rd_addr->rd_data/rd_meta_o; FIFO_D, 16, output skid FIFO depth.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock, all logic on posedge;
- rst_n, in, 1, reset, asynchronous, active-low;
- start, in, 1, begin drain of [first_addr, last_addr];
- first_addr, in, D_L, first bucket to drain;
- last_addr, in, D_L, last bucket to drain;
- timestamp, in, 64, free-running time;
- busy, out, 1, drain or warm-up in progress;
- done, out, 1, one-cycle completion pulse;
- epoch_ts, out, 64, new init_ts for bucket storage;
- bs_rd_addr, out, D_L, storage read address;
- bs_rd_meta, out, M, storage read meta;
- bs_rd_data, in, N*W, storage read data;
- bs_rd_meta_o, in, M, storage returned meta;
- out_valid, out, 1, stream valid;
- out_ready, in, 1, stream ready;
- out_data, out, N*W, bucket contents;
- out_addr, out, D_L, bucket index;
- out_last, out, 1, final bucket of drain.
REQ-003 Elaboration SHALL fail if M < D_L+2 or FIFO_D < RD_LAT+2.

Function
REQ-004 bs_rd_meta SHALL be {zero pad, valid, last, addr}: addr in [D_L-1:0], last at bit D_L, valid at bit D_L+1; idle cycles SHALL drive valid=0.
REQ-005 FSM states SHALL be WARM, IDLE, ISSUE, FLUSH, FIN.
REQ-006 WARM SHALL be entered on reset and last RD_LAT+1 cycles after rst_n release, then go to IDLE; busy=1 in WARM; start is ignored in WARM.
REQ-007 IDLE: start=1 SHALL latch range and go to ISSUE next cycle; start is ignored in every non-IDLE state.
REQ-008 If first_addr > last_addr at start, the FSM SHALL go directly to FIN, issue no reads and emit no beats.
REQ-009 ISSUE SHALL issue one read per cycle (valid=1, addr incrementing from first_addr) whenever credits > 0; no read when credits = 0.
REQ-010 Credits SHALL init to FIFO_D, decrement on each issued read, increment on each out_valid&out_ready; simultaneous issue and pop SHALL leave credits unchanged; credits never exceed FIFO_D or drop below 0.
REQ-011 The read issuing last_addr SHALL carry last=1 and move ISSUE->FLUSH; last_addr = D-1 SHALL terminate without address wrap.
REQ-012 Returns with bs_rd_meta_o valid=1 SHALL be pushed into the FIFO as {bs_rd_data, addr, last}; returns with valid=0 SHALL be discarded; the FIFO SHALL never overflow given REQ-010.
REQ-013 out_* SHALL present the FIFO head; out_valid=1 iff FIFO non-empty; data/addr/last SHALL hold stable while out_valid&!out_ready.
REQ-014 FLUSH SHALL go to FIN on the cycle the out_last beat handshakes.
REQ-015 FIN SHALL last one cycle: done=1, epoch_ts <= timestamp, then IDLE.
REQ-016 Read-to-output latency with out_ready=1 SHALL be RD_LAT+1 cycles; sustained throughput SHALL be 1 bucket/cycle.
REQ-017 busy SHALL be 1 in WARM, ISSUE, FLUSH, FIN; 0 in IDLE.

Reset
REQ-018 rst_n=0 SHALL immediately force: state WARM, busy=1, done=0, out_valid=0, bs_rd_meta valid=0, bs_rd_addr=0, credits=FIFO_D, FIFO empty, epoch_ts=0.
REQ-019 Reset mid-drain SHALL abort with no done pulse; returns still in flight SHALL be absorbed by WARM and never appear on out_*.

Verification
REQ-020 Range 0..15, out_ready=1, storage model with RD_LAT=7 -> 16 beats, addr 0..15, out_last on addr 15, first beat 8 cycles after first read, done 1 cycle after last beat, epoch_ts = timestamp at FIN.
REQ-021 Range 0..63, out_ready=0 for 40 cycles then 1 -> exactly 16 reads issued before stall, no beat lost or duplicated, 64 beats in order.
REQ-022 first_addr=5, last_addr=4 -> no reads, no beats, done pulses 2 cycles after start.
REQ-023 Range D-2..D-1 -> 2 beats, no read to address 0, out_last on D-1.
REQ-024 rst_n low for 1 cycle during ISSUE of range 0..31 -> outputs reset immediately, busy=1 for 8 cycles, start during WARM ignored, next start 0..3 yields exactly 4 clean beats.
REQ-025 start asserted while busy -> ignored, range and beat count of current drain unchanged.
